// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: stall bit meanings, stall vectors, FSM states.
package pipe_ctrl_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam int STALL_PC    = 0;
  localparam int STALL_IF_ID = 1;
  localparam int STALL_ID_EX = 2;
  localparam int STALL_EX_MM = 3;
  localparam int STALL_MM_WB = 4;
  localparam int STALL_WB    = 5;

  // Each vector freezes every register upstream of the requesting stage.
  localparam logic [5:0] STALL_V_MEM  = {NOSTOP, STOP,   STOP,   STOP,   STOP,   STOP};
  localparam logic [5:0] STALL_V_EX   = {NOSTOP, NOSTOP, STOP,   STOP,   STOP,   STOP};
  localparam logic [5:0] STALL_V_ID   = {NOSTOP, NOSTOP, NOSTOP, STOP,   STOP,   STOP};
  localparam logic [5:0] STALL_V_IF   = {NOSTOP, NOSTOP, NOSTOP, NOSTOP, STOP,   STOP};
  localparam logic [5:0] STALL_V_NONE = 6'b000000;

  typedef enum logic {
    CTRL_RUN  = 1'b0,
    CTRL_PEND = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_stall_enc.sv
// Priority encoder from per-stage stall requests to the 6-bit stall vector.
// Purely combinational; the deepest requesting stage wins.
module pipe_stall_enc
  import pipe_ctrl_pkg::*;
(
  input  logic       req_if,
  input  logic       req_id,
  input  logic       req_ex,
  input  logic       req_mem,
  output logic [5:0] stall
);

  always_comb begin
    stall = STALL_V_NONE;
    if (req_mem)     stall = STALL_V_MEM;
    else if (req_ex) stall = STALL_V_EX;
    else if (req_id) stall = STALL_V_ID;
    else if (req_if) stall = STALL_V_IF;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush control with a one-deep pending redirect held across freezes.
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = 64
`ifdef PIPE_CTRL_PERF_EN
  , parameter int PERF_W = 32
`endif
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_if,
  input  logic            stallreq_id,
  input  logic            stallreq_ex,
  input  logic            stallreq_mem,
  input  logic            br_flush_req,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_target,
  output logic [5:0]      stall,
  output logic            flush,
  output logic [XLEN-1:0] new_pc
`ifdef PIPE_CTRL_PERF_EN
  , output logic [PERF_W-1:0] stall_cycles
  , output logic [PERF_W-1:0] flush_count
`endif
);

  ctrl_state_t     state;
  logic [XLEN-1:0] pend_pc;
  logic            pend_is_trap;

  logic            hold;
  logic [5:0]      enc_stall;
  logic            flush_c;
  logic [XLEN-1:0] new_pc_c;
  logic            latch_en;
  logic [XLEN-1:0] latch_pc;
  logic            latch_trap;

  assign hold = stallreq_ex | stallreq_mem;

  pipe_stall_enc u_enc (
    .req_if  (stallreq_if),
    .req_id  (stallreq_id),
    .req_ex  (stallreq_ex),
    .req_mem (stallreq_mem),
    .stall   (enc_stall)
  );

  always_comb begin
    flush_c    = 1'b0;
    new_pc_c   = '0;
    latch_en   = 1'b0;
    latch_pc   = pend_pc;
    latch_trap = pend_is_trap;
    if (state == CTRL_RUN) begin
      if (trap_req && !stallreq_mem) begin
        flush_c  = 1'b1;
        new_pc_c = trap_target;
      end else if (trap_req) begin
        latch_en   = 1'b1;
        latch_pc   = trap_target;
        latch_trap = 1'b1;
      end else if (br_flush_req && !hold) begin
        flush_c  = 1'b1;
        new_pc_c = br_target;
      end else if (br_flush_req) begin
        latch_en   = 1'b1;
        latch_pc   = br_target;
        latch_trap = 1'b0;
      end
    end else begin
      // A trap is older than the held branch, so it replaces it even on the release cycle.
      if (trap_req && !pend_is_trap) begin
        latch_en   = 1'b1;
        latch_pc   = trap_target;
        latch_trap = 1'b1;
      end
      if (!hold) begin
        flush_c  = 1'b1;
        new_pc_c = latch_pc;
      end
    end
  end

  // Reset forces the outputs quiet even while inputs are still active.
  assign flush  = rst & flush_c;
  assign new_pc = rst ? new_pc_c : '0;
  assign stall  = (rst && !flush_c) ? enc_stall : STALL_V_NONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= CTRL_RUN;
      pend_pc      <= '0;
      pend_is_trap <= 1'b0;
    end else begin
      if (latch_en) begin
        pend_pc      <= latch_pc;
        pend_is_trap <= latch_trap;
      end
      case (state)
        CTRL_RUN:  if (latch_en) state <= CTRL_PEND;
        CTRL_PEND: if (flush_c)  state <= CTRL_RUN;
        default:                 state <= CTRL_RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall != STALL_V_NONE) stall_cycles <= stall_cycles + 1'b1;
      if (flush)                 flush_count  <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random traffic against a redirect model.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        sif, sid, sex, smem, br, trap;
  logic [63:0] br_t, tr_t;
  logic [5:0]  stall;
  logic        flush;
  logic [63:0] new_pc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: an optional pending redirect (target + whether it came from a trap) and counters.
  bit          m_pend, m_trap;
  logic [63:0] m_pc;
  int unsigned m_sc, m_fc;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (sif),
    .stallreq_id  (sid),
    .stallreq_ex  (sex),
    .stallreq_mem (smem),
    .br_flush_req (br),
    .br_target    (br_t),
    .trap_req     (trap),
    .trap_target  (tr_t),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles (stall_cycles)
    , .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] stall_table(logic i_f, logic i_d, logic e, logic m);
    if (m)   return 6'b011111;
    if (e)   return 6'b001111;
    if (i_d) return 6'b000111;
    if (i_f) return 6'b000011;
    return 6'b000000;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(logic i_f, logic i_d, logic e, logic m, logic b, logic [63:0] bt,
                        logic t, logic [63:0] tt);
    sif = i_f; sid = i_d; sex = e; smem = m; br = b; br_t = bt; trap = t; tr_t = tt;
  endtask

  task automatic model_reset();
    m_pend = 0; m_trap = 0; m_pc = '0; m_sc = 0; m_fc = 0;
  endtask

  // Inputs are already driven; check at negedge, advance the model at posedge.
  task automatic run_cycle(string tag);
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [63:0] e_pc;
    bit          n_pend, n_trap;
    logic [63:0] n_pc;
    logic        hold;
    @(negedge clk);
    hold    = sex | smem;
    e_stall = stall_table(sif, sid, sex, smem);
    e_flush = 0; e_pc = '0;
    n_pend = m_pend; n_trap = m_trap; n_pc = m_pc;
    if (!m_pend) begin
      if (trap && !smem) begin e_flush = 1; e_pc = tr_t; end
      else if (trap)     begin n_pend = 1; n_pc = tr_t; n_trap = 1; end
      else if (br && !hold) begin e_flush = 1; e_pc = br_t; end
      else if (br)       begin n_pend = 1; n_pc = br_t; n_trap = 0; end
    end else begin
      if (trap && !m_trap) begin n_pc = tr_t; n_trap = 1; end
      if (!hold) begin e_flush = 1; e_pc = n_pc; n_pend = 0; end
    end
    if (e_flush) e_stall = '0;
    chk({tag, "_stall"}, 64'(stall), 64'(e_stall));
    chk({tag, "_flush"}, 64'(flush), 64'(e_flush));
    chk({tag, "_new_pc"}, new_pc, e_pc);
`ifdef PIPE_CTRL_PERF_EN
    chk({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(m_sc));
    chk({tag, "_flush_count"}, 64'(flush_count), 64'(m_fc));
`endif
    @(posedge clk);
    m_pend = n_pend; m_trap = n_trap; m_pc = n_pc;
    if (e_stall != 0) m_sc++;
    if (e_flush) m_fc++;
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_stall"}, 64'(stall), 64'd0);
    chk({tag, "_flush"}, 64'(flush), 64'd0);
    chk({tag, "_new_pc"}, new_pc, 64'd0);
`ifdef PIPE_CTRL_PERF_EN
    chk({tag, "_stall_cycles"}, 64'(stall_cycles), 64'd0);
    chk({tag, "_flush_count"}, 64'(flush_count), 64'd0);
`endif
  endtask

  initial begin
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, '0, 0, '0);
    model_reset();
    #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Single-cycle load-use stall.
    set_in(0, 1, 0, 0, 0, '0, 0, '0);
    run_cycle("id_stall");
    set_in(0, 0, 0, 0, 0, '0, 0, '0);
    run_cycle("idle");

    // mem outranks id.
    set_in(0, 1, 0, 1, 0, '0, 0, '0);
    run_cycle("mem_id");

    // Unheld branch redirects in the same cycle.
    set_in(1, 1, 0, 0, 1, 64'h8000_0040, 0, '0);
    run_cycle("br_now");

    // Branch held by ex for 3 cycles, released when ex drops.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 1, 0, 1, 64'h8000_0080, 0, '0);
      run_cycle("br_held");
    end
    set_in(0, 0, 0, 0, 1, 64'h8000_0080, 0, '0);
    run_cycle("br_release");
    set_in(0, 0, 0, 0, 0, '0, 0, '0);
    run_cycle("after_release");

    // Trap arriving in PEND overrides the held branch.
    set_in(0, 0, 1, 0, 1, 64'h100, 0, '0);
    run_cycle("pend_br");
    set_in(0, 0, 1, 0, 1, 64'h100, 1, 64'h200);
    run_cycle("pend_trap");
    set_in(0, 0, 0, 0, 0, '0, 0, '0);
    run_cycle("trap_release");
    run_cycle("single_pulse");

    // Trap with mem wait is held; a trap without mem wait fires even while ex is busy.
    set_in(0, 0, 0, 1, 0, '0, 1, 64'h300);
    run_cycle("trap_held");
    set_in(0, 0, 0, 0, 0, '0, 0, '0);
    run_cycle("trap_held_release");
    set_in(0, 0, 1, 0, 1, 64'h400, 1, 64'h500);
    run_cycle("trap_beats_br");

    // Asynchronous reset mid-PEND with live inputs.
    set_in(0, 0, 1, 0, 1, 64'h600, 0, '0);
    run_cycle("pre_rst_pend");
    set_in(1, 1, 1, 0, 1, 64'h600, 1, 64'h700);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_pend_reset");
    model_reset();
    @(posedge clk); #1;
    set_in(0, 0, 0, 0, 0, '0, 0, '0);
    rst = 1'b1;
    run_cycle("post_rst_quiet");
    run_cycle("post_rst_quiet2");

`ifdef PIPE_CTRL_PERF_EN
    rst = 1'b0; #1; model_reset(); @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, 0, 0, 0, '0, 0, '0);
      run_cycle("perf_stall");
    end
    set_in(0, 0, 0, 0, 1, 64'h40, 0, '0);
    run_cycle("perf_flush1");
    set_in(0, 0, 0, 0, 0, '0, 1, 64'h80);
    run_cycle("perf_flush2");
    set_in(0, 0, 0, 0, 0, '0, 0, '0);
    run_cycle("perf_idle");
    chk("perf_stall_cycles_5", 64'(stall_cycles), 64'd5);
    chk("perf_flush_count_2", 64'(flush_count), 64'd2);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
             ($urandom % 4) == 0, ($urandom % 3) == 0, {$urandom, $urandom},
             ($urandom % 6) == 0, {$urandom, $urandom});
      run_cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
